tinytpu_seq_ctrl: RTL and testbench
===================================

# tinytpu_seq_ctrl

Sequencer for the tinytpu N×N systolic MAC array. It deserialises operand matrices X and Y from the two 1‑bit input pins and clears the array. It then feeds operands with the systolic skew, captures the result matrix Z and streams it out bit‑serially with a valid strobe. It sits between the top‑level pin mapping and the PE array: the array is pure datapath, and every cycle‑level decision lives here.

## Interface
- D_W, 8, operand width (bits)
- N, 2, array dimension; N ≥ 2
- ACC_W, 2*D_W+$clog2(N), accumulator/result width (17 at defaults)
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active‑high reset
- data_in_x  in  1  serial X bit, LSB first
- data_in_y  in  1  serial Y bit, LSB first
- load_en  in  1  qualifies data_in_x/y in LOAD
- init  in  1  start/restart request
- arr_x  out  N*D_W  row operands; slice i = row i
- arr_y  out  N*D_W  column operands; slice j = column j
- arr_valid  out  1  array accumulates this cycle
- arr_clr  out  1  array zeroes accumulators this cycle
- arr_z  in  N*N*ACC_W  array results; slice i*N+j = Z[i][j]
- data_out_z  out  1  serial Z bit, LSB first
- tx_ready  out  1  data_out_z valid this cycle
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, LOAD, CLR, FEED, WAIT, TX.
- IDLE → LOAD on init = 1; bit counter, word buffers and skew counter cleared.
- LOAD: each cycle with load_en = 1 shifts one X bit and one Y bit in. Both matrices are row‑major, element (0,0) first, D_W bits per element: N*N*D_W bits total (32 at defaults). load_en = 0 pauses with no loss of state. The cycle after the last bit → CLR.
- CLR: one cycle; arr_clr = 1, arr_valid = 0 → FEED.
- FEED: 3N−2 cycles, t = 0..3N−3, arr_valid = 1.
  - arr_x row i = X[i][t−i] when 0 ≤ t−i < N, else 0.
  - arr_y col j = Y[t−j][j] when 0 ≤ t−j < N, else 0.
  - After the last FEED cycle → WAIT.
- WAIT: one cycle; arr_valid = 0. At its end arr_z is latched into the TX shift register → TX.
- TX: N*N*ACC_W cycles (68 at defaults); tx_ready = 1. Z is sent row‑major, Z[0][0] first, LSB first per element. After the last bit → IDLE.
- init = 1 in any non‑IDLE state: abort and go to LOAD with counters cleared. In‑flight TX is dropped (tx_ready low next cycle). init has priority over every other transition.
- load_en is ignored outside LOAD. data_in_x/y are ignored when load_en = 0.
- Results are not saturated; ACC_W is wide enough by construction.

## Timing
- All outputs are registered.
- Reset values: arr_x = 0, arr_y = 0, arr_valid = 0, arr_clr = 0, data_out_z = 0, tx_ready = 0, busy = 0, state = IDLE.
- Cycle numbering: init sampled at edge 0; LOAD active from cycle 1.
- With load_en held high at defaults:
  - LOAD cycles 1–32
  - CLR cycle 33
  - FEED cycles 34–37
  - WAIT cycle 38
  - TX cycles 39–106, first bit at cycle 39
  - IDLE from cycle 107
- Latency from last loaded bit to first Z bit = 3N+1 cycles.
- init in the final TX cycle: abort wins; next state is LOAD, not IDLE.
- rst mid‑operation: immediate return to reset values. No partial output follows.

## Structure
- tinytpu_pkg holds:
  - the state enum
  - ACC_W derivation helper
  - counter width constants (bit count, feed count, tx count)
- Sub‑module tinytpu_skew_feeder: a combinational per‑row/column element select from t and the word buffers.
- FSM, counters and serdes stay in tinytpu_seq_ctrl.

## Test plan
- Reset: assert rst mid‑TX → all outputs 0 same cycle; busy = 0; no tx_ready after release.
- Basic matmul: X = [[1,2],[3,4]], Y = [[5,6],[7,8]], load_en always high, behavioural array model → serial Z = 19, 22, 43, 50. First tx_ready at cycle 39, last at 106.
- Gapped load: load_en toggled 1/0 every cycle with the same data → same Z. CLR occurs 32 load cycles plus gaps after init.
- Skew check: in FEED monitor arr_x/arr_y → t0 (1,0)/(5,0), t1 (2,3)/(7,6), t2 (0,4)/(0,8), t3 zeros. arr_clr precedes the first valid by exactly 1 cycle.
- Max operands: all elements 255 → each Z = 130050 (0x1FC02) in 17 bits, no truncation.
- Abort: init at TX bit 10 → tx_ready drops next cycle, state LOAD. A new load of identity X with the Y above → Z = 5, 6, 7, 8.

Source files
------------

// File: rtl/tinytpu_pkg.sv
// Shared types and width helpers for the tinytpu sequencer.
// State encoding plus functions that derive accumulator and counter widths.
package tinytpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CLR,
    ST_FEED,
    ST_WAIT,
    ST_TX
  } state_t;

  localparam int DEF_D_W = 8;
  localparam int DEF_N   = 2;

  // Room for N products of two D_W-bit operands without overflow.
  function automatic int acc_width(input int d_w, input int n);
    return 2 * d_w + $clog2(n);
  endfunction

  // Width of a counter that runs 0..span-1.
  function automatic int cnt_width(input int span);
    return (span < 2) ? 1 : $clog2(span);
  endfunction

  function automatic int bit_cnt_width(input int d_w, input int n);
    return cnt_width(n * n * d_w);
  endfunction

  function automatic int feed_cnt_width(input int n);
    return cnt_width(3 * n - 2);
  endfunction

  function automatic int tx_cnt_width(input int acc_w, input int n);
    return cnt_width(n * n * acc_w);
  endfunction

endpackage

// File: rtl/tinytpu_skew_feeder.sv
// Skewed operand select: row i carries X[i][t-i], column j carries Y[t-j][j],
// zero outside the diagonal band.
module tinytpu_skew_feeder
  import tinytpu_pkg::*;
#(
  parameter int D_W = DEF_D_W,
  parameter int N   = DEF_N,
  parameter int T_W = feed_cnt_width(DEF_N)
) (
  input  logic [T_W-1:0]       t,
  input  logic [N*N*D_W-1:0]   x_buf,
  input  logic [N*N*D_W-1:0]   y_buf,
  output logic [N*D_W-1:0]     x_row,
  output logic [N*D_W-1:0]     y_col
);

  always_comb begin
    x_row = '0;
    y_col = '0;
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < N; k++) begin
        if (int'(t) == i + k) begin
          x_row[i*D_W +: D_W] = x_buf[(i*N+k)*D_W +: D_W];
          y_col[i*D_W +: D_W] = y_buf[(k*N+i)*D_W +: D_W];
        end
      end
    end
  end

endmodule

// File: rtl/tinytpu_seq_ctrl.sv
// Sequencer for the tinytpu systolic MAC array: serial operand load, array
// clear, skewed feed, result capture and bit-serial result transmit.
module tinytpu_seq_ctrl
  import tinytpu_pkg::*;
#(
  parameter int D_W   = DEF_D_W,
  parameter int N     = DEF_N,
  parameter int ACC_W = acc_width(D_W, N)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   data_in_x,
  input  logic                   data_in_y,
  input  logic                   load_en,
  input  logic                   init,
  output logic [N*D_W-1:0]       arr_x,
  output logic [N*D_W-1:0]       arr_y,
  output logic                   arr_valid,
  output logic                   arr_clr,
  input  logic [N*N*ACC_W-1:0]   arr_z,
  output logic                   data_out_z,
  output logic                   tx_ready,
  output logic                   busy
);

  localparam int TOT_IN   = N * N * D_W;
  localparam int TOT_Z    = N * N * ACC_W;
  localparam int FEED_LEN = 3 * N - 2;
  localparam int BIT_W    = bit_cnt_width(D_W, N);
  localparam int FEED_W   = feed_cnt_width(N);
  localparam int TXC_W    = tx_cnt_width(ACC_W, N);

  state_t state, state_nxt;

  logic [BIT_W-1:0]  bit_cnt;
  logic [FEED_W-1:0] feed_cnt;
  logic [TXC_W-1:0]  tx_cnt;
  logic [TOT_IN-1:0] x_buf, y_buf;
  logic [TOT_Z-1:0]  tx_sr, tx_sr_nxt;
  logic [FEED_W-1:0] t_nxt;
  logic [N*D_W-1:0]  feed_x, feed_y;
  logic              last_bit, last_feed, last_tx;

  logic [N*D_W-1:0]  arr_x_nxt, arr_y_nxt;
  logic              arr_valid_nxt, arr_clr_nxt, data_out_z_nxt, tx_ready_nxt, busy_nxt;

  assign last_bit  = (bit_cnt == BIT_W'(TOT_IN - 1));
  assign last_feed = (feed_cnt == FEED_W'(FEED_LEN - 1));
  assign last_tx   = (tx_cnt == TXC_W'(TOT_Z - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (init) begin
      state_nxt = ST_LOAD;
    end else begin
      case (state)
        ST_IDLE: state_nxt = ST_IDLE;
        ST_LOAD: if (load_en && last_bit) state_nxt = ST_CLR;
        ST_CLR:  state_nxt = ST_FEED;
        ST_FEED: if (last_feed) state_nxt = ST_WAIT;
        ST_WAIT: state_nxt = ST_TX;
        ST_TX:   if (last_tx) state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt  <= '0;
      feed_cnt <= '0;
      tx_cnt   <= '0;
    end else if (init) begin
      bit_cnt  <= '0;
      feed_cnt <= '0;
      tx_cnt   <= '0;
    end else begin
      if (state == ST_LOAD && load_en) bit_cnt <= last_bit ? '0 : bit_cnt + BIT_W'(1);
      if (state == ST_FEED) feed_cnt <= last_feed ? '0 : feed_cnt + FEED_W'(1);
      if (state == ST_TX) tx_cnt <= last_tx ? '0 : tx_cnt + TXC_W'(1);
    end
  end

  // Bits enter at the top so the first bit received ends up at bit 0.
  always_ff @(posedge clk) begin
    if (init) begin
      x_buf <= '0;
      y_buf <= '0;
    end else if (state == ST_LOAD && load_en) begin
      x_buf <= {data_in_x, x_buf[TOT_IN-1:1]};
      y_buf <= {data_in_y, y_buf[TOT_IN-1:1]};
    end
  end

  assign tx_sr_nxt = (state == ST_WAIT) ? arr_z : (tx_sr >> 1);

  always_ff @(posedge clk) begin
    if (state == ST_WAIT || state == ST_TX) tx_sr <= tx_sr_nxt;
  end

  // Outputs are registered, so the feeder looks at the t of the coming cycle.
  assign t_nxt = (state == ST_FEED) ? feed_cnt + FEED_W'(1) : '0;

  tinytpu_skew_feeder #(
    .D_W (D_W),
    .N   (N),
    .T_W (FEED_W)
  ) u_skew_feeder (
    .t     (t_nxt),
    .x_buf (x_buf),
    .y_buf (y_buf),
    .x_row (feed_x),
    .y_col (feed_y)
  );

  always_comb begin
    arr_x_nxt      = '0;
    arr_y_nxt      = '0;
    arr_valid_nxt  = 1'b0;
    arr_clr_nxt    = 1'b0;
    data_out_z_nxt = 1'b0;
    tx_ready_nxt   = 1'b0;
    busy_nxt       = (state_nxt != ST_IDLE);
    case (state_nxt)
      ST_CLR:  arr_clr_nxt = 1'b1;
      ST_FEED: begin
        arr_valid_nxt = 1'b1;
        arr_x_nxt     = feed_x;
        arr_y_nxt     = feed_y;
      end
      ST_TX: begin
        tx_ready_nxt   = 1'b1;
        data_out_z_nxt = tx_sr_nxt[0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arr_x      <= '0;
      arr_y      <= '0;
      arr_valid  <= 1'b0;
      arr_clr    <= 1'b0;
      data_out_z <= 1'b0;
      tx_ready   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      arr_x      <= arr_x_nxt;
      arr_y      <= arr_y_nxt;
      arr_valid  <= arr_valid_nxt;
      arr_clr    <= arr_clr_nxt;
      data_out_z <= data_out_z_nxt;
      tx_ready   <= tx_ready_nxt;
      busy       <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_tinytpu_seq_ctrl.sv
// Bench for tinytpu_seq_ctrl: a behavioural systolic array drives arr_z and
// results are compared against plain matrix products of the loaded operands.
module tb_tinytpu_seq_ctrl;

  localparam int D_W      = 8;
  localparam int N        = 2;
  localparam int ACC_W    = 17;
  localparam int TOT_IN   = N * N * D_W;
  localparam int TOT_Z    = N * N * ACC_W;
  localparam int FEED_LEN = 3 * N - 2;
  localparam int MAXC     = 600;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 data_in_x, data_in_y, load_en, init;
  logic [N*D_W-1:0]     arr_x, arr_y;
  logic                 arr_valid, arr_clr;
  logic [N*N*ACC_W-1:0] arr_z;
  logic                 data_out_z, tx_ready, busy;

  always #5 clk = ~clk;

  tinytpu_seq_ctrl #(.D_W(D_W), .N(N), .ACC_W(ACC_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in_x  (data_in_x),
    .data_in_y  (data_in_y),
    .load_en    (load_en),
    .init       (init),
    .arr_x      (arr_x),
    .arr_y      (arr_y),
    .arr_valid  (arr_valid),
    .arr_clr    (arr_clr),
    .arr_z      (arr_z),
    .data_out_z (data_out_z),
    .tx_ready   (tx_ready),
    .busy       (busy)
  );

  // Behavioural systolic array: x flows right, y flows down, one hop per cycle.
  logic [D_W-1:0]   xr [N][N];
  logic [D_W-1:0]   yr [N][N];
  logic [D_W-1:0]   pa [N][N];
  logic [D_W-1:0]   pb [N][N];
  logic [ACC_W-1:0] acc[N][N];

  always_comb begin
    arr_z = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        pa[i][j] = (j == 0) ? arr_x[i*D_W +: D_W] : xr[i][(j > 0) ? j - 1 : 0];
        pb[i][j] = (i == 0) ? arr_y[j*D_W +: D_W] : yr[(i > 0) ? i - 1 : 0][j];
        arr_z[(i*N+j)*ACC_W +: ACC_W] = acc[i][j];
      end
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        xr[i][j] <= pa[i][j];
        yr[i][j] <= pb[i][j];
        if (arr_clr) acc[i][j] <= '0;
        else if (arr_valid) acc[i][j] <= acc[i][j] + ACC_W'(pa[i][j]) * ACC_W'(pb[i][j]);
      end
    end
  end

  int unsigned xm[N][N];
  int unsigned ym[N][N];

  int   n_vec = 0;
  int   n_err = 0;
  int   last_bit_cyc, first_tx, last_tx, idle_cyc, n_tx;
  int   clr_cyc[$];
  int   vld_cyc[$];
  logic [N*D_W-1:0] fx_q[$];
  logic [N*D_W-1:0] fy_q[$];
  logic z_bits[$];

  function automatic logic [ACC_W-1:0] exp_z(input int i, input int j);
    int unsigned s = 0;
    for (int k = 0; k < N; k++) s += xm[i][k] * ym[k][j];
    return ACC_W'(s);
  endfunction

  function automatic logic [ACC_W-1:0] got_z(input int e);
    logic [ACC_W-1:0] v;
    if (z_bits.size() != TOT_Z) return 'x;
    for (int b = 0; b < ACC_W; b++) v[b] = z_bits[e*ACC_W + b];
    return v;
  endfunction

  function automatic logic [N*D_W-1:0] exp_fx(input int t);
    logic [N*D_W-1:0] r = '0;
    for (int i = 0; i < N; i++)
      if (t - i >= 0 && t - i < N) r[i*D_W +: D_W] = D_W'(xm[i][t-i]);
    return r;
  endfunction

  function automatic logic [N*D_W-1:0] exp_fy(input int t);
    logic [N*D_W-1:0] r = '0;
    for (int j = 0; j < N; j++)
      if (t - j >= 0 && t - j < N) r[j*D_W +: D_W] = D_W'(ym[t-j][j]);
    return r;
  endfunction

  function automatic int first_of(input int q[$]);
    return (q.size() > 0) ? q[0] : -1;
  endfunction

  // Runs one operation; cycle n is the n-th cycle after init was sampled.
  // gap_mode: 0 load_en always high, 1 alternating, 2 random.
  task automatic run_op(input int gap_mode, input bit skip_init, input int abort_at,
                        input bit abort_rst);
    int sent = 0;
    bit want;
    int e, b;
    first_tx = -1; last_tx = -1; idle_cyc = -1; last_bit_cyc = -1; n_tx = 0;
    clr_cyc.delete(); vld_cyc.delete(); fx_q.delete(); fy_q.delete(); z_bits.delete();
    if (!skip_init) begin
      @(negedge clk);
      init = 1'b1;
      load_en = 1'($urandom);
      @(negedge clk);
      init = 1'b0;
    end
    for (int n = 1; n <= MAXC; n++) begin
      if (n > 1) @(negedge clk);
      if (!busy) begin
        idle_cyc = n;
        break;
      end
      if (arr_clr) clr_cyc.push_back(n);
      if (arr_valid) begin
        vld_cyc.push_back(n);
        fx_q.push_back(arr_x);
        fy_q.push_back(arr_y);
      end
      if (tx_ready) begin
        if (first_tx < 0) first_tx = n;
        last_tx = n;
        z_bits.push_back(data_out_z);
        n_tx++;
        if (n_tx == abort_at + 1) begin
          if (abort_rst) rst = 1'b1;
          else init = 1'b1;
          load_en = 1'b0;
          return;
        end
      end
      data_in_x = 1'($urandom);
      data_in_y = 1'($urandom);
      load_en   = 1'($urandom);
      if (sent < TOT_IN) begin
        case (gap_mode)
          0:       want = 1'b1;
          1:       want = (n % 2 == 1);
          default: want = 1'($urandom);
        endcase
        load_en = want;
        if (want) begin
          e = sent / D_W;
          b = sent % D_W;
          data_in_x = 1'((xm[e/N][e%N] >> b) & 1);
          data_in_y = 1'((ym[e/N][e%N] >> b) & 1);
          sent++;
          if (sent == TOT_IN) last_bit_cyc = n;
        end
      end
    end
    load_en = 1'b0;
    n_vec++;
    if (idle_cyc < 0) begin
      n_err++;
      $display("FAIL op_timeout: got no return to idle within %0d cycles, required idle", MAXC);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({arr_x, arr_y} !== '0) begin
      n_err++;
      $display("FAIL reset_operands: got %0h required 0", {arr_x, arr_y});
    end
    n_vec++;
    if ({arr_valid, arr_clr, data_out_z, tx_ready, busy} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_flags: got %b required 00000",
               {arr_valid, arr_clr, data_out_z, tx_ready, busy});
    end
    rst = 1'b0;
    load_en = 1'b1;
    repeat (4) @(negedge clk);
    load_en = 1'b0;
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL idle_ignores_load_en: got busy=%b required 0", busy);
    end
  endtask

  task automatic test_basic;
    xm = '{'{1, 2}, '{3, 4}};
    ym = '{'{5, 6}, '{7, 8}};
    run_op(0, 1'b0, -1, 1'b0);
    for (int e = 0; e < N * N; e++) begin
      n_vec++;
      if (got_z(e) !== exp_z(e / N, e % N)) begin
        n_err++;
        $display("FAIL basic_z%0d: got %0d required %0d", e, got_z(e), exp_z(e / N, e % N));
      end
    end
    n_vec++;
    if (first_tx !== 39 || last_tx !== 106 || n_tx !== TOT_Z) begin
      n_err++;
      $display("FAIL basic_tx_window: got first=%0d last=%0d bits=%0d required 39 106 %0d",
               first_tx, last_tx, n_tx, TOT_Z);
    end
    n_vec++;
    if (idle_cyc !== 107) begin
      n_err++;
      $display("FAIL basic_idle_cycle: got %0d required 107", idle_cyc);
    end
  endtask

  task automatic test_skew;
    xm = '{'{1, 2}, '{3, 4}};
    ym = '{'{5, 6}, '{7, 8}};
    run_op(0, 1'b0, -1, 1'b0);
    n_vec++;
    if (clr_cyc.size() != 1 || first_of(clr_cyc) != 33) begin
      n_err++;
      $display("FAIL skew_clr: got %0d pulses first at %0d required 1 pulse at 33",
               clr_cyc.size(), first_of(clr_cyc));
    end
    n_vec++;
    if (vld_cyc.size() != FEED_LEN || first_of(vld_cyc) != first_of(clr_cyc) + 1) begin
      n_err++;
      $display("FAIL skew_valid: got %0d cycles from %0d required %0d cycles from %0d",
               vld_cyc.size(), first_of(vld_cyc), FEED_LEN, first_of(clr_cyc) + 1);
    end
    for (int t = 0; t < FEED_LEN; t++) begin
      n_vec++;
      if (t >= fx_q.size() || fx_q[t] !== exp_fx(t) || fy_q[t] !== exp_fy(t)) begin
        n_err++;
        $display("FAIL skew_t%0d: got x=%0h y=%0h required x=%0h y=%0h", t,
                 (t < fx_q.size()) ? fx_q[t] : 'x, (t < fy_q.size()) ? fy_q[t] : 'x,
                 exp_fx(t), exp_fy(t));
      end
    end
  endtask

  task automatic test_gapped;
    xm = '{'{1, 2}, '{3, 4}};
    ym = '{'{5, 6}, '{7, 8}};
    run_op(1, 1'b0, -1, 1'b0);
    for (int e = 0; e < N * N; e++) begin
      n_vec++;
      if (got_z(e) !== exp_z(e / N, e % N)) begin
        n_err++;
        $display("FAIL gapped_z%0d: got %0d required %0d", e, got_z(e), exp_z(e / N, e % N));
      end
    end
    n_vec++;
    if (first_of(clr_cyc) != 64 || first_tx != 70) begin
      n_err++;
      $display("FAIL gapped_timing: got clr=%0d first_tx=%0d required 64 70",
               first_of(clr_cyc), first_tx);
    end
  endtask

  task automatic test_max;
    xm = '{'{255, 255}, '{255, 255}};
    ym = '{'{255, 255}, '{255, 255}};
    run_op(0, 1'b0, -1, 1'b0);
    for (int e = 0; e < N * N; e++) begin
      n_vec++;
      if (got_z(e) !== 17'd130050) begin
        n_err++;
        $display("FAIL max_z%0d: got %0d required 130050", e, got_z(e));
      end
    end
  endtask

  task automatic test_abort;
    xm = '{'{1, 2}, '{3, 4}};
    ym = '{'{5, 6}, '{7, 8}};
    run_op(0, 1'b0, 10, 1'b0);
    @(negedge clk);
    init = 1'b0;
    n_vec++;
    if (tx_ready !== 1'b0 || busy !== 1'b1 || data_out_z !== 1'b0) begin
      n_err++;
      $display("FAIL abort_drop: got tx_ready=%b busy=%b dout=%b required 0 1 0",
               tx_ready, busy, data_out_z);
    end
    xm = '{'{1, 0}, '{0, 1}};
    run_op(0, 1'b1, -1, 1'b0);
    for (int e = 0; e < N * N; e++) begin
      n_vec++;
      if (got_z(e) !== ACC_W'(e + 5)) begin
        n_err++;
        $display("FAIL abort_reload_z%0d: got %0d required %0d", e, got_z(e), e + 5);
      end
    end
    n_vec++;
    if (first_tx != 39) begin
      n_err++;
      $display("FAIL abort_reload_first_tx: got %0d required 39", first_tx);
    end
  endtask

  task automatic test_abort_last;
    xm = '{'{9, 1}, '{2, 3}};
    ym = '{'{4, 0}, '{6, 7}};
    run_op(2, 1'b0, TOT_Z - 1, 1'b0);
    @(negedge clk);
    init = 1'b0;
    n_vec++;
    if (busy !== 1'b1 || tx_ready !== 1'b0) begin
      n_err++;
      $display("FAIL abort_last_bit: got busy=%b tx_ready=%b required 1 0", busy, tx_ready);
    end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        xm[i][j] = $urandom_range(0, 255);
        ym[i][j] = $urandom_range(0, 255);
      end
    run_op(0, 1'b1, -1, 1'b0);
    for (int e = 0; e < N * N; e++) begin
      n_vec++;
      if (got_z(e) !== exp_z(e / N, e % N)) begin
        n_err++;
        $display("FAIL abort_last_z%0d: got %0d required %0d", e, got_z(e), exp_z(e / N, e % N));
      end
    end
  endtask

  task automatic test_reset_mid;
    bit seen = 1'b0;
    xm = '{'{1, 2}, '{3, 4}};
    ym = '{'{5, 6}, '{7, 8}};
    run_op(0, 1'b0, 20, 1'b1);
    #1;
    n_vec++;
    if ({arr_x, arr_y, arr_valid, arr_clr, data_out_z, tx_ready, busy} !== '0) begin
      n_err++;
      $display("FAIL rst_mid_outputs: got %0h required 0",
               {arr_x, arr_y, arr_valid, arr_clr, data_out_z, tx_ready, busy});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 120; n++) begin
      @(negedge clk);
      if (tx_ready !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    n_vec++;
    if (seen) begin
      n_err++;
      $display("FAIL rst_mid_quiet: got activity after reset release required none");
    end
  endtask

  task automatic test_random;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          xm[i][j] = $urandom_range(0, 255);
          ym[i][j] = $urandom_range(0, 255);
        end
      run_op(2, 1'b0, -1, 1'b0);
      for (int e = 0; e < N * N; e++) begin
        n_vec++;
        if (got_z(e) !== exp_z(e / N, e % N)) begin
          n_err++;
          $display("FAIL random%0d_z%0d: got %0d required %0d", r, e, got_z(e),
                   exp_z(e / N, e % N));
        end
      end
      n_vec++;
      if (first_tx != last_bit_cyc + 3 * N + 1 || last_tx != first_tx + TOT_Z - 1 ||
          first_of(clr_cyc) != last_bit_cyc + 1) begin
        n_err++;
        $display("FAIL random%0d_timing: got clr=%0d first=%0d last=%0d required %0d %0d %0d",
                 r, first_of(clr_cyc), first_tx, last_tx, last_bit_cyc + 1,
                 last_bit_cyc + 3 * N + 1, last_bit_cyc + 3 * N + TOT_Z);
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    init      = 1'b0;
    load_en   = 1'b0;
    data_in_x = 1'b0;
    data_in_y = 1'b0;
    test_reset;
    test_basic;
    test_skew;
    test_gapped;
    test_max;
    test_abort;
    test_abort_last;
    test_reset_mid;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
